// File: rtl/vme_arb_pkg.sv
// Shared definitions for the VME round-robin bus arbiter: state encoding,
// active-low signal levels, requester count and the round-robin pick.
package vme_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int REQ_W   = 2;

  localparam logic ACTIVE   = 1'b0;
  localparam logic INACTIVE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2,
    ST_CLEAR = 2'd3
  } arb_state_t;

  // req is active-high here; the search starts just after last and wraps.
  function automatic logic [REQ_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [REQ_W-1:0]   last);
    logic [REQ_W-1:0] idx;
    logic [REQ_W-1:0] win;
    logic             found;
    win   = last;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = last + REQ_W'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/vme_bus_timer.sv
// VME transfer watchdog: drives BERR when a strobed cycle sees no DTACK for
// BUS_TIMEOUT cycles, holding it until the address strobe is released.
module vme_bus_timer #(
  parameter int unsigned BUS_TIMEOUT = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic address_strobe,
  input  logic dtack,
  output logic berr
);
  import vme_arb_pkg::*;

  localparam int CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(BUS_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;
  logic             counting;

  assign counting = (address_strobe == ACTIVE) && (dtack == INACTIVE);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt  <= '0;
      berr <= INACTIVE;
    end else begin
      if (!counting)
        cnt <= '0;
      else if (cnt != CNT_TC)
        cnt <= cnt + 1'b1;

      // Once raised, BERR is held for the rest of the strobe even if DTACK arrives.
      if (address_strobe == INACTIVE)
        berr <= INACTIVE;
      else if (counting && cnt == CNT_TC)
        berr <= ACTIVE;
    end
  end

endmodule

// File: rtl/vme_rr_arbiter.sv
// Four-requester round-robin VME bus arbiter with grant timeout and bus clear.
// Optional BERR watchdog is built only when VME_BUS_TIMEOUT_EN is defined.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no grant out; waiting for a request while bus is free
// ST_GRANT | bgout[owner] low; waiting for owner to assert BBSY
// ST_BUSY  | owner holds BBSY; watching for competing requests
// ST_CLEAR | bclr low; waiting for owner to release BBSY
module vme_rr_arbiter #(
  parameter int unsigned GRANT_TIMEOUT = 16,
  parameter int unsigned BUS_TIMEOUT   = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] vme_br,
  input  logic       vme_bbsy,
  input  logic       vme_address_strobe,
  input  logic       vme_dtack,
  output logic [3:0] vme_bgout,
  output logic       vme_bclr,
  output logic       vme_berr,
  output logic [1:0] owner,
  output logic       owner_valid
);
  import vme_arb_pkg::*;

  localparam int GT_W = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
  localparam logic [GT_W-1:0] GT_TC = GT_W'(GRANT_TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] NO_GRANT = {NUM_REQ{INACTIVE}};

  arb_state_t       state;
  logic [REQ_W-1:0] last_owner;
  logic [GT_W-1:0]  gnt_cnt;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] own_mask;
  logic [REQ_W-1:0]   winner;
  logic               bus_free;

  assign req      = ~vme_br;
  assign own_mask = NUM_REQ'(1) << owner;
  assign winner   = rr_pick(req, last_owner);
  assign bus_free = (vme_bbsy == INACTIVE);

  assign owner_valid = (state == ST_GRANT) || (state == ST_BUSY);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      vme_bgout  <= NO_GRANT;
      vme_bclr   <= INACTIVE;
      owner      <= '0;
      last_owner <= REQ_W'(NUM_REQ - 1);
      gnt_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          vme_bgout <= NO_GRANT;
          vme_bclr  <= INACTIVE;
          if ((|req) && bus_free) begin
            owner     <= winner;
            vme_bgout <= ~(NUM_REQ'(1) << winner);
            gnt_cnt   <= '0;
            state     <= ST_GRANT;
          end
        end

        ST_GRANT: begin
          if (!bus_free) begin
            vme_bgout <= NO_GRANT;
            state     <= ST_BUSY;
          end else if (vme_br[owner] == INACTIVE) begin
            vme_bgout <= NO_GRANT;
            state     <= ST_IDLE;
          end else if (gnt_cnt == GT_TC) begin
            // Recording the stalled requester as last owner pushes it to the back.
            vme_bgout  <= NO_GRANT;
            last_owner <= owner;
            state      <= ST_IDLE;
          end else begin
            gnt_cnt <= gnt_cnt + 1'b1;
          end
        end

        ST_BUSY: begin
          // Release wins over a competing request so the newcomer goes through IDLE.
          if (bus_free) begin
            last_owner <= owner;
            state      <= ST_IDLE;
          end else if (|(req & ~own_mask)) begin
            vme_bclr <= ACTIVE;
            state    <= ST_CLEAR;
          end
        end

        ST_CLEAR: begin
          if (bus_free) begin
            vme_bclr   <= INACTIVE;
            last_owner <= owner;
            state      <= ST_IDLE;
          end
        end

        default: begin
          vme_bgout <= NO_GRANT;
          vme_bclr  <= INACTIVE;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef VME_BUS_TIMEOUT_EN
  vme_bus_timer #(
    .BUS_TIMEOUT(BUS_TIMEOUT)
  ) u_bus_timer (
    .clock          (clock),
    .reset          (reset),
    .address_strobe (vme_address_strobe),
    .dtack          (vme_dtack),
    .berr           (vme_berr)
  );
`else
  localparam int unsigned unused_bus_timeout = BUS_TIMEOUT;
  logic unused_watchdog_inputs;
  assign unused_watchdog_inputs = &{1'b0, vme_address_strobe, vme_dtack};
  assign vme_berr = INACTIVE;
`endif

endmodule

// File: tb/tb_vme_rr_arbiter.sv
// Directed bench for vme_rr_arbiter: a cycle-by-cycle vector table plus
// hand-written grant-timeout, reset and watchdog sequences.
module tb_vme_rr_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] vme_br;
  logic       vme_bbsy;
  logic       vme_address_strobe;
  logic       vme_dtack;
  logic [3:0] vme_bgout;
  logic       vme_bclr;
  logic       vme_berr;
  logic [1:0] owner;
  logic       owner_valid;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  vme_rr_arbiter #(
    .GRANT_TIMEOUT(16),
    .BUS_TIMEOUT  (8)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .vme_br             (vme_br),
    .vme_bbsy           (vme_bbsy),
    .vme_address_strobe (vme_address_strobe),
    .vme_dtack          (vme_dtack),
    .vme_bgout          (vme_bgout),
    .vme_bclr           (vme_bclr),
    .vme_berr           (vme_berr),
    .owner              (owner),
    .owner_valid        (owner_valid)
  );

  typedef struct {
    logic       rst;
    logic [3:0] br;
    logic       bbsy;
    logic [3:0] bgout;
    logic       bclr;
    logic [1:0] own;
    logic       valid;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic rst, input logic [3:0] br, input logic bbsy,
                              input logic [3:0] bgout, input logic bclr,
                              input logic [1:0] own, input logic valid);
    vec_t v;
    v.rst = rst; v.br = br; v.bbsy = bbsy;
    v.bgout = bgout; v.bclr = bclr; v.own = own; v.valid = valid;
    vq.push_back(v);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] bgout, input logic bclr,
                           input logic [1:0] own, input logic valid);
    check({tag, ".bgout"}, {4'h0, vme_bgout}, {4'h0, bgout});
    check({tag, ".bclr"},  {7'h0, vme_bclr},  {7'h0, bclr});
    check({tag, ".berr"},  {7'h0, vme_berr},  8'h01);
    check({tag, ".owner"}, {6'h0, owner},     {6'h0, own});
    check({tag, ".valid"}, {7'h0, owner_valid}, {7'h0, valid});
  endtask

  initial begin
    reset = 1'b1; vme_br = 4'b1111; vme_bbsy = 1'b1;
    vme_address_strobe = 1'b1; vme_dtack = 1'b1;

    //  rst  br       bbsy  bgout    bclr  own    valid
    add(1, 4'b1111, 1, 4'b1111, 1, 2'd0, 0);   // reset state
    // Round robin 0,1,2,3,0 with all requesting
    add(0, 4'b0000, 1, 4'b1110, 1, 2'd0, 1);
    add(0, 4'b0000, 0, 4'b1111, 1, 2'd0, 1);
    add(0, 4'b0000, 1, 4'b1111, 1, 2'd0, 0);
    add(0, 4'b0000, 1, 4'b1101, 1, 2'd1, 1);
    add(0, 4'b0000, 0, 4'b1111, 1, 2'd1, 1);
    add(0, 4'b0000, 1, 4'b1111, 1, 2'd1, 0);
    add(0, 4'b0000, 1, 4'b1011, 1, 2'd2, 1);
    add(0, 4'b0000, 0, 4'b1111, 1, 2'd2, 1);
    add(0, 4'b0000, 1, 4'b1111, 1, 2'd2, 0);
    add(0, 4'b0000, 1, 4'b0111, 1, 2'd3, 1);
    add(0, 4'b0000, 0, 4'b1111, 1, 2'd3, 1);
    add(0, 4'b0000, 1, 4'b1111, 1, 2'd3, 0);
    add(0, 4'b0000, 1, 4'b1110, 1, 2'd0, 1);
    add(0, 4'b0000, 0, 4'b1111, 1, 2'd0, 1);
    add(0, 4'b0000, 1, 4'b1111, 1, 2'd0, 0);
    // Single request from reset
    add(1, 4'b1111, 1, 4'b1111, 1, 2'd0, 0);
    add(0, 4'b1011, 1, 4'b1011, 1, 2'd2, 1);
    add(0, 4'b1011, 0, 4'b1111, 1, 2'd2, 1);
    add(0, 4'b1111, 0, 4'b1111, 1, 2'd2, 1);
    add(0, 4'b1111, 1, 4'b1111, 1, 2'd2, 0);
    // Preemption of owner 2 by requester 0
    add(0, 4'b1011, 1, 4'b1011, 1, 2'd2, 1);
    add(0, 4'b1011, 0, 4'b1111, 1, 2'd2, 1);
    add(0, 4'b1010, 0, 4'b1111, 0, 2'd2, 0);
    add(0, 4'b1110, 0, 4'b1111, 0, 2'd2, 0);
    add(0, 4'b1110, 1, 4'b1111, 1, 2'd2, 0);
    add(0, 4'b1110, 1, 4'b1110, 1, 2'd0, 1);
    // Request withdrawn during grant leaves last owner at 2
    add(0, 4'b1111, 1, 4'b1111, 1, 2'd0, 0);
    add(0, 4'b0101, 1, 4'b0111, 1, 2'd3, 1);
    // Release and competing request in the same cycle go through IDLE
    add(0, 4'b0101, 0, 4'b1111, 1, 2'd3, 1);
    add(0, 4'b0101, 1, 4'b1111, 1, 2'd3, 0);
    add(0, 4'b0101, 1, 4'b1101, 1, 2'd1, 1);
    add(0, 4'b1111, 1, 4'b1111, 1, 2'd1, 0);

    for (int i = 0; i < vq.size(); i++) begin
      reset = vq[i].rst; vme_br = vq[i].br; vme_bbsy = vq[i].bbsy;
      step();
      check_all($sformatf("vec%0d", i), vq[i].bgout, vq[i].bclr, vq[i].own, vq[i].valid);
    end

    // Grant timeout: requester 1 never asserts BBSY; 1 and 3 keep requesting
    reset = 1'b1; vme_br = 4'b1111; vme_bbsy = 1'b1;
    step();
    reset = 1'b0; vme_br = 4'b0101;
    step();
    check_all("gto.grant", 4'b1101, 1, 2'd1, 1);
    for (int i = 1; i < 16; i++) begin
      step();
      check($sformatf("gto.hold%0d", i), {4'h0, vme_bgout}, 8'h0d);
    end
    step();
    check_all("gto.release", 4'b1111, 1, 2'd1, 0);
    step();
    check_all("gto.next", 4'b0111, 1, 2'd3, 1);

    // Reset while a grant is out
    reset = 1'b1;
    step();
    check_all("rst.grant", 4'b1111, 1, 2'd0, 0);

    // Reset during BUSY with bclr asserted
    reset = 1'b0; vme_br = 4'b1011; vme_bbsy = 1'b1;
    step();
    vme_bbsy = 1'b0;
    step();
    vme_br = 4'b1010;
    step();
    check_all("rst.pre", 4'b1111, 0, 2'd2, 0);
    reset = 1'b1;
    step();
    check_all("rst.clear", 4'b1111, 1, 2'd0, 0);
    reset = 1'b0; vme_br = 4'b1111; vme_bbsy = 1'b1;
    step();
    check_all("rst.idle", 4'b1111, 1, 2'd0, 0);

`ifdef VME_BUS_TIMEOUT_EN
    // Watchdog: no DTACK for 8 cycles raises BERR until AS releases
    vme_address_strobe = 1'b0; vme_dtack = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      check($sformatf("wd.quiet%0d", i), {7'h0, vme_berr}, 8'h01);
    end
    step();
    check("wd.berr8", {7'h0, vme_berr}, 8'h00);
    vme_dtack = 1'b0;
    step();
    check("wd.held", {7'h0, vme_berr}, 8'h00);
    vme_address_strobe = 1'b1; vme_dtack = 1'b1;
    step();
    check("wd.release", {7'h0, vme_berr}, 8'h01);
    vme_address_strobe = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      vme_dtack = (i == 5) ? 1'b0 : 1'b1;
      step();
      if (i < 12)
        check($sformatf("wd.dtack%0d", i), {7'h0, vme_berr}, 8'h01);
    end
    // DTACK at cycle 5 restarted the count, so BERR is due 8 cycles after it
    check("wd.restart", {7'h0, vme_berr}, 8'h00);
    vme_address_strobe = 1'b1;
    step();
`else
    vme_address_strobe = 1'b0; vme_dtack = 1'b1;
    for (int i = 1; i <= 10; i++) step();
    check("berr.const", {7'h0, vme_berr}, 8'h01);
    vme_address_strobe = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vme_rr_arbiter.md
VME_RR_ARBITER -- requirements
Module: vme_rr_arbiter

Interface
- REQ-001 SHALL have parameter GRANT_TIMEOUT, default 16: cycles a granted requester has to assert BBSY before its grant is withdrawn.
- REQ-002 SHALL have parameter BUS_TIMEOUT, default 1024: cycles a transfer may stay unacknowledged before BERR is driven.
- REQ-003 SHALL have port `clock`: input, 1 bit, single system clock for all logic.
- REQ-004 SHALL have port `reset`: input, 1 bit. Reset is synchronous and active-high.
- REQ-005 SHALL have port `vme_br`: input, 4 bits, bus requests, active-low, index 0..3.
- REQ-006 SHALL have port `vme_bbsy`: input, 1 bit, bus busy as sensed, active-low.
- REQ-007 SHALL have port `vme_address_strobe`: input, 1 bit, active-low.
- REQ-008 SHALL have port `vme_dtack`: input, 1 bit, active-low.
- REQ-009 SHALL have port `vme_bgout`: output, 4 bits, bus grants, active-low, registered.
- REQ-010 SHALL have port `vme_bclr`: output, 1 bit, bus clear, active-low, registered.
- REQ-011 SHALL have port `vme_berr`: output, 1 bit, bus error, active-low, registered.
- REQ-012 SHALL have port `owner`: output, 2 bits, index of the current or last granted requester.
- REQ-013 SHALL have port `owner_valid`: output, 1 bit, high while in GRANT or BUSY.

Function
- REQ-014 SHALL implement states IDLE, GRANT, BUSY and CLEAR.
- REQ-015 IDLE SHALL hold `vme_bgout`=4'b1111 and `vme_bclr`=1.
  - If any `vme_br` bit is 0 and `vme_bbsy`=1: select the winner, drive `vme_bgout[winner]`=0 and go to GRANT, with 1-cycle latency.
- REQ-016 Winner selection SHALL be round-robin: search from last_owner+1 upward, wrapping modulo 4. Ties never occur.
- REQ-017 In GRANT, when `vme_bbsy`=0: release the grant (`vme_bgout`=4'b1111) and go to BUSY.
- REQ-018 In GRANT, when `vme_br[owner]` returns to 1 before BBSY is asserted: release the grant and go to IDLE.
- REQ-019 In GRANT, when the grant counter reaches GRANT_TIMEOUT-1 without BBSY: release the grant, set last_owner=owner and go to IDLE, so the stalled requester is skipped next.
- REQ-020 In BUSY, when any `vme_br[i]`=0 with i≠owner: drive `vme_bclr`=0 and go to CLEAR.
- REQ-021 In BUSY, when `vme_bbsy`=1: set last_owner=owner and go to IDLE.
- REQ-022 In CLEAR, `vme_bclr` SHALL stay 0 until `vme_bbsy`=1. Then set `vme_bclr`=1, set last_owner=owner and go to IDLE.
- REQ-023 A new request from a different requester in the same cycle that BBSY releases SHALL be served from IDLE on the next cycle. It SHALL NOT be granted directly from BUSY or CLEAR.
- REQ-024 At most one `vme_bgout` bit SHALL be 0 at any time.
- REQ-025 The grant counter SHALL clear on entry to GRANT and SHALL saturate, never wrap.
- REQ-026 An illegal state encoding SHALL return to IDLE with all outputs inactive.

Reset
- REQ-027 When `reset`=1 at a clock edge, the block SHALL enter IDLE and drive `vme_bgout`=4'b1111, `vme_bclr`=1 and `vme_berr`=1.
  - Other registers: last_owner=3 (so requester 0 has first priority), `owner`=0, counters=0.
- REQ-028 Reset mid-transfer SHALL withdraw every grant and clear at the same edge.

Configuration
- REQ-029 With `VME_BUS_TIMEOUT_EN` defined, a watchdog SHALL count cycles while `vme_address_strobe`=0 and `vme_dtack`=1.
  - At count BUS_TIMEOUT-1, it SHALL drive `vme_berr`=0 and hold it until `vme_address_strobe`=1.
  - The count SHALL clear whenever AS=1 or DTACK=0.
- REQ-030 Without `VME_BUS_TIMEOUT_EN`, `vme_berr` SHALL be constant 1 and no watchdog logic SHALL be instantiated.

Structure
- REQ-031 Package vme_arb_pkg SHALL hold the state encoding, the ACTIVE=0/INACTIVE=1 constants and the requester count (4).
- REQ-032 The watchdog SHALL be sub-module vme_bus_timer, instantiated only under `VME_BUS_TIMEOUT_EN`.

Verification
- REQ-033 Single request: br=4'b1011 from reset → `vme_bgout`=4'b1011 after 1 cycle. BBSY=0 → bgout=4'b1111 and state BUSY. BBSY=1 → IDLE.
- REQ-034 Round-robin fairness: br=4'b0000 held, each owner cycling BBSY → grant order 0,1,2,3,0.
- REQ-035 Preemption: owner 2 busy, br[0]=0 → `vme_bclr`=0 next cycle. BBSY=1 → bclr=1, then grant to 0.
- REQ-036 Grant timeout: br[1]=0, BBSY never asserted → grant withdrawn after 16 cycles. With br=4'b0101 pending, the next grant goes to 3.
- REQ-037 Bus timeout (macro on, BUS_TIMEOUT=8): AS=0, DTACK=1 → `vme_berr`=0 on cycle 8, held until AS=1. DTACK=0 at cycle 5 → no BERR.
- REQ-038 Reset during BUSY with bclr=0 → all outputs inactive at the next edge and state IDLE.
